// File: rtl/ldtu_gain_window_ctrl_if.sv
// ----------------------------------------------------------------------------
// ldtu_gain_window_ctrl_if
// Groups the signals between the gain-window controller and its surroundings.
//   GAIN_SEL_MODE : window/force mode select (00 short, 01 long, 10 x10, 11 x1)
//   ref_sat       : gain-x10 look-ahead sample at/above saturation
//   win_clr       : synchronous clear of the window counter
//   sel_g1        : registered mux select (1 = gain x1, 0 = gain x10)
//   win_start     : one-cycle pulse on the first sel_g1=1 cycle of a window
//   win_abort     : one-cycle pulse when an open window is killed by a mode change
//   win_active    : high while the controller holds a window open
//   win_cnt       : saturating count of windows opened
//   ctrl_state    : FSM state (SETTLE=00, IDLE=01, HOLD=10, FORCE=11)
// master: the side driving mode/ref_sat/win_clr. slave: the controller.
// ----------------------------------------------------------------------------
interface ldtu_gain_window_ctrl_if #(
    parameter int CNT_W = 8
);
    logic [1:0]       GAIN_SEL_MODE;
    logic             ref_sat;
    logic             win_clr;
    logic             sel_g1;
    logic             win_start;
    logic             win_abort;
    logic             win_active;
    logic [CNT_W-1:0] win_cnt;
    logic [1:0]       ctrl_state;

    modport master (
        output GAIN_SEL_MODE, ref_sat, win_clr,
        input  sel_g1, win_start, win_abort, win_active, win_cnt, ctrl_state
    );

    modport slave (
        input  GAIN_SEL_MODE, ref_sat, win_clr,
        output sel_g1, win_start, win_abort, win_active, win_cnt, ctrl_state
    );
endinterface

// File: rtl/ldtu_gain_window_ctrl.sv
// ----------------------------------------------------------------------------
// ldtu_gain_window_ctrl
// LiTe-DTU gain selection window controller. Chooses which gain path (x1 or
// x10) feeds the encoder. In window modes a saturating x10 look-ahead sample
// opens (or retriggers) a gain-x1 hold window of W cycles; force modes pin the
// selection. Every reset or mode change is followed by a settle guard during
// which the look-ahead pipeline refills and ref_sat is ignored.
// Ports:
//   CLK   : clock, all state on its rising edge
//   rst_b : asynchronous active-low reset
//   bus   : slave side of ldtu_gain_window_ctrl_if (mode, ref_sat, win_clr in;
//           sel_g1, win_start, win_abort, win_active, win_cnt, ctrl_state out)
// All outputs come straight from registers.
// ----------------------------------------------------------------------------
module ldtu_gain_window_ctrl #(
    parameter int WIN_SHORT  = 8,
    parameter int WIN_LONG   = 16,
    parameter int SETTLE_LEN = 16,
    parameter int CNT_W      = 8
) (
    input  logic                   CLK,
    input  logic                   rst_b,
    ldtu_gain_window_ctrl_if.slave bus
);

    localparam int HOLD_W = (WIN_LONG > 1) ? $clog2(WIN_LONG) : 1;
    localparam int SET_W  = (SETTLE_LEN > 1) ? $clog2(SETTLE_LEN) : 1;

    localparam logic [HOLD_W-1:0] HOLD_SHORT  = HOLD_W'(WIN_SHORT - 1);
    localparam logic [HOLD_W-1:0] HOLD_LONG   = HOLD_W'(WIN_LONG - 1);
    localparam logic [SET_W-1:0]  SETTLE_INIT = SET_W'(SETTLE_LEN - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX     = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_SETTLE = 2'b00,
        ST_IDLE   = 2'b01,
        ST_HOLD   = 2'b10,
        ST_FORCE  = 2'b11
    } state_t;

    state_t            state_q;
    logic [1:0]        mode_q;
    logic [SET_W-1:0]  settle_cnt_q;
    logic [HOLD_W-1:0] hold_cnt_q;
    logic              sel_g1_q;
    logic              win_start_q;
    logic              win_abort_q;
    logic              win_active_q;
    logic [CNT_W-1:0]  win_cnt_q;

    logic              mode_chg;
    logic [HOLD_W-1:0] hold_reload;
    logic              win_open;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    assign mode_chg    = (bus.GAIN_SEL_MODE != mode_q);
    assign hold_reload = (bus.GAIN_SEL_MODE == 2'b01) ? HOLD_LONG : HOLD_SHORT;
    // A new window opens only from IDLE; a mode change in the same cycle wins.
    assign win_open    = (state_q == ST_IDLE) && !mode_chg && bus.ref_sat;

    always_ff @(posedge CLK or negedge rst_b) begin
        if (!rst_b) begin
            state_q      <= ST_SETTLE;
            mode_q       <= 2'b00;
            settle_cnt_q <= SETTLE_INIT;
            hold_cnt_q   <= '0;
            sel_g1_q     <= 1'b0;
            win_start_q  <= 1'b0;
            win_abort_q  <= 1'b0;
            win_active_q <= 1'b0;
            win_cnt_q    <= '0;
        end else begin
            mode_q      <= bus.GAIN_SEL_MODE;
            win_start_q <= 1'b0;
            win_abort_q <= 1'b0;

            // Clear beats a coincident window start.
            if (bus.win_clr) begin
                win_cnt_q <= '0;
            end else if (win_open) begin
                win_cnt_q <= sat_inc(win_cnt_q);
            end

            if (mode_chg) begin
                // Any mode change restarts the guard, even mid-settle.
                state_q      <= ST_SETTLE;
                settle_cnt_q <= SETTLE_INIT;
                sel_g1_q     <= (bus.GAIN_SEL_MODE == 2'b11);
                win_active_q <= 1'b0;
                win_abort_q  <= (state_q == ST_HOLD);
            end else begin
                case (state_q)
                    ST_SETTLE: begin
                        if (settle_cnt_q == '0) begin
                            if (mode_q[1]) begin
                                state_q  <= ST_FORCE;
                                sel_g1_q <= mode_q[0];
                            end else begin
                                state_q  <= ST_IDLE;
                                sel_g1_q <= 1'b0;
                            end
                        end else begin
                            settle_cnt_q <= settle_cnt_q - SET_W'(1);
                            sel_g1_q     <= (mode_q == 2'b11);
                        end
                    end
                    ST_IDLE: begin
                        if (bus.ref_sat) begin
                            state_q      <= ST_HOLD;
                            hold_cnt_q   <= hold_reload;
                            sel_g1_q     <= 1'b1;
                            win_start_q  <= 1'b1;
                            win_active_q <= 1'b1;
                        end else begin
                            sel_g1_q <= 1'b0;
                        end
                    end
                    ST_HOLD: begin
                        // hold_cnt reaches 0 in the W-th x1 cycle after the last ref_sat.
                        if (bus.ref_sat) begin
                            hold_cnt_q <= hold_reload;
                        end else if (hold_cnt_q == '0) begin
                            state_q      <= ST_IDLE;
                            sel_g1_q     <= 1'b0;
                            win_active_q <= 1'b0;
                        end else begin
                            hold_cnt_q <= hold_cnt_q - HOLD_W'(1);
                        end
                    end
                    ST_FORCE: begin
                        sel_g1_q <= mode_q[0];
                    end
                    default: begin
                        state_q      <= ST_SETTLE;
                        settle_cnt_q <= SETTLE_INIT;
                        sel_g1_q     <= 1'b0;
                        win_active_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.sel_g1     = sel_g1_q;
    assign bus.win_start  = win_start_q;
    assign bus.win_abort  = win_abort_q;
    assign bus.win_active = win_active_q;
    assign bus.win_cnt    = win_cnt_q;
    assign bus.ctrl_state = state_q;

endmodule

// File: tb/tb_ldtu_gain_window_ctrl.sv
// ----------------------------------------------------------------------------
// tb_ldtu_gain_window_ctrl
// Directed plus randomized stimulus for ldtu_gain_window_ctrl. The reference
// model tracks cycle stamps (last mode change, window open/close cycle) and
// derives every expected output from them each cycle.
// ----------------------------------------------------------------------------
module tb_ldtu_gain_window_ctrl;

    localparam int WS  = 8;
    localparam int WL  = 16;
    localparam int SL  = 16;
    localparam int CW  = 8;
    localparam int CMX = (1 << CW) - 1;

    logic CLK = 1'b0;
    logic rst_b;
    always #5 CLK = ~CLK;

    ldtu_gain_window_ctrl_if #(.CNT_W(CW)) bus ();

    ldtu_gain_window_ctrl #(
        .WIN_SHORT (WS),
        .WIN_LONG  (WL),
        .SETTLE_LEN(SL),
        .CNT_W     (CW)
    ) dut (
        .CLK  (CLK),
        .rst_b(rst_b),
        .bus  (bus)
    );

    int checks = 0;
    int passes = 0;

    // Reference model state: cycle stamps relative to the last reset release.
    int         cyc;
    int         chg_c;
    int         win_open;
    int         win_end;
    int         start_at;
    int         abort_at;
    int         m_cnt;
    logic [1:0] mq;

    function automatic int wlen(input logic [1:0] m);
        return (m == 2'b01) ? WL : WS;
    endfunction

    // 0 settle, 1 idle, 2 hold, 3 force at cycle n.
    function automatic int exp_state(input int n);
        if (n <= chg_c + SL) return 0;
        if (mq[1]) return 3;
        if (win_open <= n && n <= win_end) return 2;
        return 1;
    endfunction

    task automatic model_reset();
        cyc      = 0;
        chg_c    = -1;
        mq       = 2'b00;
        win_open = 0;
        win_end  = -1000;
        start_at = -1000;
        abort_at = -1000;
        m_cnt    = 0;
    endtask

    task automatic model_edge(input logic [1:0] m, input logic r, input logic c);
        int e;
        bit hold_e;
        bit neww;
        e      = cyc;
        hold_e = (exp_state(e) == 2);
        neww   = 1'b0;
        if (m != mq) begin
            if (hold_e) abort_at = e + 1;
            win_end = -1000;
            chg_c   = e;
        end else if (e > chg_c + SL && !mq[1] && r) begin
            if (hold_e) begin
                win_end = e + wlen(m);
            end else begin
                win_open = e + 1;
                win_end  = e + wlen(m);
                start_at = e + 1;
                neww     = 1'b1;
            end
        end
        mq = m;
        if (c) m_cnt = 0;
        else if (neww && m_cnt < CMX) m_cnt = m_cnt + 1;
        cyc = e + 1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) passes = passes + 1;
        else $error("FAIL %s cyc=%0d got=%0d expected=%0d", tag, cyc, obs, exp);
    endtask

    task automatic check_all();
        int  st;
        logic sel;
        st = exp_state(cyc);
        if (st == 0)      sel = (mq == 2'b11);
        else if (st == 3) sel = mq[0];
        else              sel = (st == 2);
        check("ctrl_state", bus.ctrl_state, st);
        check("sel_g1",     bus.sel_g1,     sel);
        check("win_start",  bus.win_start,  start_at == cyc);
        check("win_abort",  bus.win_abort,  abort_at == cyc);
        check("win_active", bus.win_active, st == 2);
        check("win_cnt",    bus.win_cnt,    m_cnt);
    endtask

    task automatic drive(input logic [1:0] m, input logic r, input logic c);
        bus.GAIN_SEL_MODE = m;
        bus.ref_sat       = r;
        bus.win_clr       = c;
    endtask

    task automatic step();
        @(posedge CLK);
        model_edge(bus.GAIN_SEL_MODE, bus.ref_sat, bus.win_clr);
        #1;
        check_all();
    endtask

    initial begin
        int base;
        int starts;
        int dens;
        logic [1:0] rm;

        rst_b = 1'b0;
        drive(2'b00, 1'b0, 1'b0);
        repeat (2) @(posedge CLK);
        #1;
        check("rst_state",  bus.ctrl_state, 2'b00);
        check("rst_sel",    bus.sel_g1,     1'b0);
        check("rst_start",  bus.win_start,  1'b0);
        check("rst_abort",  bus.win_abort,  1'b0);
        check("rst_active", bus.win_active, 1'b0);
        check("rst_cnt",    bus.win_cnt,    0);
        @(negedge CLK);
        rst_b = 1'b1;
        model_reset();
        check_all();

        // Guard after reset with ref_sat held high, then one pulse at cycle 20.
        for (int k = 0; k < 30; k++) begin
            drive(2'b00, (k < 16) || (k == 20), 1'b0);
            step();
            if (cyc <= 15) check("guard_state", bus.ctrl_state, 2'b00);
            if (cyc == 16) check("guard_idle",  bus.ctrl_state, 2'b01);
            if (cyc == 21) check("a_start",     bus.win_start,  1'b1);
            check("a_sel", bus.sel_g1, (cyc >= 21) && (cyc <= 28));
        end
        check("a_cnt", bus.win_cnt, 1);

        // Long window with a retrigger 10 cycles after opening.
        drive(2'b01, 1'b0, 1'b0);
        repeat (SL + 1) step();
        base   = cyc;
        starts = 0;
        for (int k = 0; k < 30; k++) begin
            drive(2'b01, (k == 0) || (k == 10), 1'b0);
            step();
            starts = starts + int'(bus.win_start);
            check("b_sel", bus.sel_g1, (cyc >= base + 1) && (cyc <= base + 26));
        end
        check("b_starts", starts, 1);
        check("b_cnt", bus.win_cnt, 2);

        // Mode change to force-x1 while a window is open.
        drive(2'b00, 1'b0, 1'b0);
        repeat (SL + 1) step();
        drive(2'b00, 1'b1, 1'b0);
        step();
        drive(2'b00, 1'b0, 1'b0);
        repeat (2) step();
        check("c_hold", bus.ctrl_state, 2'b10);
        drive(2'b11, 1'b0, 1'b0);
        step();
        check("c_abort", bus.win_abort, 1'b1);
        check("c_state", bus.ctrl_state, 2'b00);
        check("c_sel",   bus.sel_g1, 1'b1);
        step();
        check("c_abort_once", bus.win_abort, 1'b0);
        repeat (14) step();
        check("c_settle_end", bus.ctrl_state, 2'b00);
        step();
        check("c_force", bus.ctrl_state, 2'b11);
        check("c_force_sel", bus.sel_g1, 1'b1);

        // Force x10 with ref_sat stuck high.
        drive(2'b10, 1'b1, 1'b0);
        repeat (SL + 1) step();
        starts = 0;
        for (int k = 0; k < 40; k++) begin
            step();
            starts = starts + int'(bus.win_start);
            check("d_sel", bus.sel_g1, 1'b0);
        end
        check("d_starts", starts, 0);
        check("d_state", bus.ctrl_state, 2'b11);

        // Randomized traffic.
        rm   = 2'b00;
        dens = 10;
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 49) == 0) begin
                rm   = 2'($urandom_range(0, 3));
                dens = $urandom_range(2, 40);
            end
            drive(rm, ($urandom_range(0, 99) < dens), ($urandom_range(0, 199) == 0));
            step();
        end

        // Counter saturation and clear against a simultaneous window start.
        drive(2'b00, 1'b0, 1'b1);
        step();
        drive(2'b00, 1'b0, 1'b0);
        repeat (SL + 1) step();
        for (int p = 0; p < 300; p++) begin
            drive(2'b00, 1'b1, 1'b0);
            step();
            drive(2'b00, 1'b0, 1'b0);
            repeat (19) step();
        end
        check("f_sat", bus.win_cnt, CMX);
        drive(2'b00, 1'b1, 1'b1);
        step();
        check("f_clr_start", bus.win_start, 1'b1);
        check("f_clr_cnt",   bus.win_cnt, 0);
        drive(2'b00, 1'b0, 1'b0);
        repeat (10) step();

        // Reset in the middle of a window.
        drive(2'b00, 1'b1, 1'b0);
        step();
        drive(2'b00, 1'b0, 1'b0);
        step();
        check("g_pre_sel", bus.sel_g1, 1'b1);
        #2;
        rst_b = 1'b0;
        #1;
        check("g_sel",    bus.sel_g1,     1'b0);
        check("g_abort",  bus.win_abort,  1'b0);
        check("g_state",  bus.ctrl_state, 2'b00);
        check("g_active", bus.win_active, 1'b0);
        check("g_cnt",    bus.win_cnt,    0);
        @(posedge CLK);
        #1;
        check("g_abort_hold", bus.win_abort, 1'b0);
        @(negedge CLK);
        rst_b = 1'b1;
        model_reset();
        check_all();
        for (int k = 0; k < 24; k++) begin
            drive(2'b00, 1'b1, 1'b0);
            step();
            if (cyc <= 16) check("g_guard_sel", bus.sel_g1, 1'b0);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
